// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, parametrised frame format and burst counter.
// Optional even/odd parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_AW      = 2,
    parameter int BURST_LEN    = 6,
    parameter int BURST_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 enable,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done,
    output logic [BURST_W-1:0]   burst_count,
    output logic                 burst_done,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]         STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
            STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 || BURST_LEN < 1 ||
            BURST_LEN > (1 << BURST_W)) begin : g_bad_param
            $error("uart_tx_fifo: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic                 push, pop;

    assign s_ready = (fifo_level != FULL_LEVEL);
    assign push    = s_valid && s_ready;

    // NOTE: the storage array has no reset; the level and pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- Serialiser ----------------
    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_n;
    logic [3:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 txd_n, busy_n, frame_done_n, burst_done_n;
    logic [BURST_W-1:0]   burst_count_n;
    logic                 wrap, load;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            txd         <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            burst_done  <= 1'b0;
            burst_count <= '0;
`ifdef UART_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_n;
            bit_cnt     <= bit_n;
            shreg       <= shreg_n;
            txd         <= txd_n;
            busy        <= busy_n;
            frame_done  <= frame_done_n;
            burst_done  <= burst_done_n;
            burst_count <= burst_count_n;
`ifdef UART_TX_PARITY_EN
            par         <= par_n;
`endif
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_n       = state;
        baud_n        = baud_cnt;
        bit_n         = bit_cnt;
        shreg_n       = shreg;
        txd_n         = txd;
        busy_n        = busy;
        frame_done_n  = 1'b0;
        burst_done_n  = 1'b0;
        burst_count_n = burst_count;
        pop           = 1'b0;
        load          = 1'b0;
        wrap          = (baud_cnt == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        par_n         = par;
`endif
        if (enable) begin
            if (state != IDLE) baud_n = wrap ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: load = (fifo_level != '0);
                START: if (wrap) begin
                    state_n = DATA;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                    shreg_n = shreg >> 1;
                end
                DATA: if (wrap) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        txd_n   = shreg[0];
                        shreg_n = shreg >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (wrap) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end
`endif
                STOP: if (wrap) begin
                    if (bit_cnt == STOP_LAST) begin
                        frame_done_n = 1'b1;
                        if (burst_count == BURST_LAST) begin
                            burst_done_n  = 1'b1;
                            burst_count_n = '0;
                        end else begin
                            burst_count_n = burst_count + 1'b1;
                        end
                        // Chain straight into the next frame when a word is waiting.
                        load = (fifo_level != '0);
                        if (!load) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (load) begin
                pop     = 1'b1;
                shreg_n = mem[rd_ptr];
                state_n = START;
                txd_n   = 1'b0;
                busy_n  = 1'b1;
                baud_n  = '0;
`ifdef UART_TX_PARITY_EN
                par_n   = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a negedge monitor decodes txd against a
// scoreboard of pushed words and checks frame_done/burst timing.
module tb_uart_tx_fifo;

    localparam int CPB        = 4;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int FIFO_AW    = 2;
    localparam int BURST_LEN  = 6;
    localparam int BURST_W    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PBITS + STOP_BITS;
    localparam int FRAME_LEN  = FRAME_BITS * CPB;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [DATA_BITS-1:0] s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic                 enable = 1'b0;
    logic                 txd, busy, frame_done, burst_done;
    logic [BURST_W-1:0]   burst_count;
    logic [FIFO_AW:0]     fifo_level;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
        .PARITY_ODD(PARITY_ODD), .FIFO_AW(FIFO_AW), .BURST_LEN(BURST_LEN), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .enable(enable), .txd(txd), .busy(busy), .frame_done(frame_done),
        .burst_count(burst_count), .burst_done(burst_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DATA_BITS-1:0] sb[$];
    int start_cyc[$];
    int done_cyc[$];
    int mon_frames = 0;
    int burst_pulses = 0;

    // Monitor state
    bit                    mon_active = 0;
    bit                    mon_bad = 0;
    int                    mon_k = 0;
    int                    exp_burst = 0;
    logic [DATA_BITS-1:0]  mon_word;
    logic [FRAME_BITS-1:0] mon_exp;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 0;
            exp_burst  = 0;
        end else begin
            if (burst_done === 1'b1) burst_pulses++;
            if (mon_active && mon_k == FRAME_LEN) begin
                checks++;
                if (frame_done !== 1'b1 || mon_bad) begin
                    errors++;
                    $display("FAIL frame word=%h frame_done=%b bits_bad=%0d", mon_word, frame_done, mon_bad);
                end
                exp_burst = (exp_burst + 1) % BURST_LEN;
                checks++;
                if (burst_count !== BURST_W'(exp_burst) || burst_done !== (exp_burst == 0)) begin
                    errors++;
                    $display("FAIL burst got count=%0d done=%b want count=%0d done=%b",
                             burst_count, burst_done, exp_burst, exp_burst == 0);
                end
                mon_frames++;
                done_cyc.push_back(cyc);
                mon_active = 0;
            end else if (frame_done === 1'b1 || burst_done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse frame_done=%b burst_done=%b want 0", frame_done, burst_done);
            end
            if (!mon_active && txd === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start got txd=0 want idle 1");
                    mon_word = 'x;
                    mon_exp  = '1;
                end else begin
                    mon_word = sb.pop_front();
                    mon_exp  = '1;
                    mon_exp[0] = 1'b0;
                    for (int i = 0; i < DATA_BITS; i++) mon_exp[1+i] = mon_word[i];
`ifdef UART_TX_PARITY_EN
                    mon_exp[1+DATA_BITS] = (^mon_word) ^ 1'(PARITY_ODD);
`endif
                end
                mon_active = 1;
                mon_bad    = 0;
                mon_k      = 0;
                start_cyc.push_back(cyc);
            end
            if (mon_active && enable === 1'b1) begin
                if (txd !== mon_exp[mon_k / CPB]) mon_bad = 1;
                mon_k++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DATA_BITS-1:0] w);
        int budget = 500;
        s_data  = w;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got s_ready=%b want 1", s_ready);
        end else begin
            sb.push_back(w);
        end
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (mon_frames < target && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (mon_frames < target) begin
            errors++;
            $display("FAIL frame_timeout got frames=%0d want %0d", mon_frames, target);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_valid = 1'b0;
        sb.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || burst_done !== 1'b0 ||
            burst_count !== '0 || fifo_level !== '0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got txd=%b busy=%b fd=%b bd=%b bc=%0d lvl=%0d rdy=%b want 1 0 0 0 0 0 1",
                     txd, busy, frame_done, burst_done, burst_count, fifo_level, s_ready);
        end
    endtask

    task automatic test_single();
        int b = mon_frames;
        enable = 1'b1;
        push_word(8'h41);
        wait_frames(b + 1, FRAME_LEN + 20);
        checks++;
        if (done_cyc[b] - start_cyc[b] !== FRAME_LEN) begin
            errors++;
            $display("FAIL single_len got %0d want %0d", done_cyc[b] - start_cyc[b], FRAME_LEN);
        end
        checks++;
        if (busy !== 1'b0 || burst_count !== 8'd1) begin
            errors++;
            $display("FAIL single_after got busy=%b bc=%0d want 0 1", busy, burst_count);
        end
    endtask

    task automatic test_back_to_back();
        int b = mon_frames;
        enable = 1'b1;
        push_word(8'h55);
        push_word(8'hAA);
        push_word(8'h0F);
        wait_frames(b + 3, 3 * FRAME_LEN + 20);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (start_cyc[b+i+1] !== done_cyc[b+i] || done_cyc[b+i+1] - done_cyc[b+i] !== FRAME_LEN) begin
                errors++;
                $display("FAIL b2b_gap%0d got start=%0d done=%0d spacing=%0d want start=done spacing=%0d",
                         i, start_cyc[b+i+1], done_cyc[b+i], done_cyc[b+i+1] - done_cyc[b+i], FRAME_LEN);
            end
        end
        checks++;
        if (done_cyc[b] - start_cyc[b] !== FRAME_LEN || fifo_level !== '0) begin
            errors++;
            $display("FAIL b2b_end got first_len=%0d lvl=%0d want %0d 0",
                     done_cyc[b] - start_cyc[b], fifo_level, FRAME_LEN);
        end
    endtask

    task automatic test_fifo_full();
        int b = mon_frames;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_data  = DATA_BITS'(8'hC0 + i);
            s_valid = 1'b1;
            checks++;
            if (s_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready%0d got %b want %b", i, s_ready, i < 4);
            end
            if (i < 4) sb.push_back(s_data);
            tick(1);
        end
        s_valid = 1'b0;
        tick(3);
        checks++;
        if (fifo_level !== 3'd4 || txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got lvl=%0d txd=%b busy=%b want 4 1 0", fifo_level, txd, busy);
        end
        enable = 1'b1;
        wait_frames(b + 4, 4 * FRAME_LEN + 20);
        tick(FRAME_LEN + 20);
        checks++;
        if (mon_frames !== b + 4 || sb.size() !== 0 || fifo_level !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got frames=%0d pending=%0d lvl=%0d busy=%b want %0d 0 0 0",
                     mon_frames - b, sb.size(), fifo_level, busy, 4);
        end
    endtask

    task automatic test_pause();
        int b = mon_frames;
        int n = 0;
        logic held;
        enable = 1'b1;
        push_word(8'hC3);
        while (start_cyc.size() <= b && n < 50) begin
            tick(1);
            n++;
        end
        tick(14);
        held   = txd;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (txd !== held || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold%0d got txd=%b busy=%b want %b 1", i, txd, busy, held);
            end
        end
        enable = 1'b1;
        wait_frames(b + 1, FRAME_LEN + 40);
        checks++;
        if (done_cyc[b] - start_cyc[b] !== FRAME_LEN + 10) begin
            errors++;
            $display("FAIL pause_len got %0d want %0d", done_cyc[b] - start_cyc[b], FRAME_LEN + 10);
        end
    endtask

    task automatic test_reset_mid();
        int b = mon_frames;
        int n = 0;
        enable = 1'b1;
        push_word(8'h99);
        push_word(8'h66);
        while (start_cyc.size() <= b && n < 50) begin
            tick(1);
            n++;
        end
        tick(15);
        do_reset();
        checks++;
        if (txd !== 1'b1 || fifo_level !== '0 || busy !== 1'b0 || burst_count !== '0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset got txd=%b lvl=%0d busy=%b bc=%0d rdy=%b want 1 0 0 0 1",
                     txd, fifo_level, busy, burst_count, s_ready);
        end
        tick(2 * FRAME_LEN);
        checks++;
        if (mon_frames !== b || txd !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet got frames=%0d txd=%b want 0 1", mon_frames - b, txd);
        end
    endtask

    task automatic test_burst();
        int b = mon_frames;
        int p = burst_pulses;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) push_word(DATA_BITS'(8'h10 * i + 3));
        wait_frames(b + 6, 6 * FRAME_LEN + 40);
        checks++;
        if (burst_pulses - p !== 1 || burst_count !== '0) begin
            errors++;
            $display("FAIL burst_total got pulses=%0d bc=%0d want 1 0", burst_pulses - p, burst_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_pause();
        test_reset_mid();
        test_burst();
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
